mem_port_arbiter: RTL and testbench

//  Shares the single memory/IO port between two requesters: M0 = core, M1 = loader/debug DMA.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port for core (M0) and loader/debug DMA (M1); 1-cycle arbitration, grants combinational.
// Bursts are capped at MAX_BURST beats under contention; read returns arrive READ_LAT cycles after the grant, tagged to the issuer.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 1,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_funct3,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_funct3,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   state_t              state;
   logic                last_owner;   // 1 = M1 owned last, so M0 wins the next tie
   logic [CNT_W-1:0]    beat_cnt;
   logic [READ_LAT-1:0] pipe_vld;
   logic [READ_LAT-1:0] pipe_id;

   logic cur;
   logic own_req;
   logic oth_req;
   logic rd_issue;

   assign m0_gnt   = (state == OWN0) & m0_req;
   assign m1_gnt   = (state == OWN1) & m1_req;
   assign cur      = (state == OWN1);
   assign own_req  = cur ? m1_req : m0_req;
   assign oth_req  = cur ? m0_req : m1_req;
   assign rd_issue = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
   assign owner    = state;

   always_comb begin
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_funct3 = '0;
      if (m0_gnt) begin
         mem_write  = m0_we;
         mem_addr   = m0_addr;
         mem_wdata  = m0_wdata;
         mem_funct3 = m0_funct3;
      end else if (m1_gnt) begin
         mem_write  = m1_we;
         mem_addr   = m1_addr;
         mem_wdata  = m1_wdata;
         mem_funct3 = m1_funct3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               if (m0_req && (!m1_req || last_owner)) state <= OWN0;
               else if (m1_req)                        state <= OWN1;
            end
            OWN0, OWN1: begin
               // Leave on owner release, or after the limit beat issues while the other side waits.
               if (!own_req || (oth_req && beat_cnt == LAST_BEAT)) begin
                  state      <= oth_req ? (cur ? OWN0 : OWN1) : IDLE;
                  last_owner <= cur;
                  beat_cnt   <= '0;
               end else if (beat_cnt != LAST_BEAT) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_vld <= '0;
         pipe_id  <= '0;
      end else begin
         pipe_vld[0] <= rd_issue;
         pipe_id[0]  <= m1_gnt;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_id[i]  <= pipe_id[i-1];
         end
      end
   end

   assign m0_rvalid = pipe_vld[READ_LAT-1] & ~pipe_id[READ_LAT-1];
   assign m1_rvalid = pipe_vld[READ_LAT-1] &  pipe_id[READ_LAT-1];
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed owner/burst scenarios plus a read-return scoreboard.
// Memory model returns f(addr) one cycle after the beat; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [2:0]  m0_funct3, m1_funct3;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_funct3;
   logic [1:0]  owner;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t    rq[$];
   logic [1:0] gq[$];
   rd_exp_t    mon_e;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rdfun(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) mem_rdata <= 32'h0;
      else        mem_rdata <= rdfun(mem_addr);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-return scoreboard: every granted read is expected back one cycle later on its issuer's port.
   always @(negedge clk) begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         mon_e = rq.pop_front();
         check_eq("rv_id", {m1_rvalid, m0_rvalid}, mon_e.id ? 2'b10 : 2'b01);
         check_eq("rv_data", mon_e.id ? m1_rdata : m0_rdata, mon_e.data);
      end else if ((m0_rvalid | m1_rvalid) !== 1'b0) begin
         check_eq("spurious_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      end
      if (m0_gnt === 1'b1 && m0_we === 1'b0) rq.push_back('{cyc + 1, 1'b0, rdfun(m0_addr)});
      if (m1_gnt === 1'b1 && m1_we === 1'b0) rq.push_back('{cyc + 1, 1'b1, rdfun(m1_addr)});
   end

   initial begin
      logic [1:0] t3 [13];
      logic [1:0] t5 [9];
      logic [1:0] g;
      logic       g0, g1;
      int         n0rv, n1rv;

      t3 = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
      t5 = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

      // 1: reset with random inputs
      reset = 1'b0;
      m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; m0_funct3 = 3'($urandom);
      m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; m1_funct3 = 3'($urandom);
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_gnt", {m1_gnt, m0_gnt}, 0);
      check_eq("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_funct3", mem_funct3, 0);
      check_eq("rst_owner", owner, 0);
      check_eq("rst_rdata", {m1_rdata, m0_rdata}, 0);
      tick();
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_funct3 = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_funct3 = 0;
      reset = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rel_owner", owner, 0);
      check_eq("rel_gnt", {m1_gnt, m0_gnt}, 0);

      // 2: single read by M0
      tick();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_funct3 = 3'b010;
      @(negedge clk);
      check_eq("t2_arb_gnt", {m1_gnt, m0_gnt}, 0);
      tick();
      @(negedge clk);
      check_eq("t2_gnt", {m1_gnt, m0_gnt}, 2'b01);
      check_eq("t2_addr", mem_addr, 32'h10);
      check_eq("t2_funct3", mem_funct3, 3'b010);
      check_eq("t2_write", mem_write, 0);
      check_eq("t2_owner", owner, 2'b01);
      tick();
      m0_req = 0;
      @(negedge clk);
      check_eq("t2_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
      check_eq("t2_rdata", m0_rdata, rdfun(32'h10));
      repeat (3) tick();

      // 3: continuous contention from reset
      reset = 1'b0;
      rq.delete();
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      m1_req = 1; m1_we = 0; m1_addr = 32'h200; m1_funct3 = 3'b001;
      tick();
      reset = 1'b1;
      foreach (t3[i]) gq.push_back(t3[i]);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         g = {m1_gnt, m0_gnt};
         check_eq("t3_rr_order", g, gq.pop_front());
         check_eq("t3_exclusive", m0_gnt & m1_gnt, 0);
         tick();
         if (g[0]) m0_addr += 4;
         if (g[1]) m1_addr += 4;
      end
      m0_req = 0; m1_req = 0;
      repeat (3) tick();

      // 4: M0 read as last beat before switch, then M1 write
      reset = 1'b0;
      rq.delete();
      m0_req = 1; m0_we = 0; m0_addr = 32'h14;
      m1_req = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'hDEADBEEF; m1_funct3 = 3'b010;
      tick();
      reset = 1'b1;
      n0rv = 0; n1rv = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 4) begin
            check_eq("t4_last_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
            check_eq("t4_last_m0_addr", mem_addr, 32'h20);
         end
         if (c == 5) begin
            check_eq("t4_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
            check_eq("t4_write", mem_write, 1);
            check_eq("t4_waddr", mem_addr, 32'h24);
            check_eq("t4_wdata", mem_wdata, 32'hDEADBEEF);
            check_eq("t4_m0_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
            check_eq("t4_m0_rdata", m0_rdata, rdfun(32'h20));
         end
         n0rv += int'(m0_rvalid);
         n1rv += int'(m1_rvalid);
         g0 = m0_gnt; g1 = m1_gnt;
         tick();
         if (g0) begin
            m0_addr += 4;
            if (m0_addr == 32'h24) m0_req = 0;
         end
         if (g1) m1_req = 0;
      end
      check_eq("t4_m0_rvalid_count", n0rv, 4);
      check_eq("t4_m1_rvalid_count", n1rv, 0);

      // 5: M1 releases early while M0 waits; M0 then gets a full burst
      m0_we = 0; m0_addr = 32'h300;
      m1_we = 1; m1_addr = 32'h400; m1_wdata = 32'h1111_2222;
      foreach (t5[i]) gq.push_back(t5[i]);
      for (int c = 0; c < 9; c++) begin
         m0_req = (c >= 1);
         m1_req = (c <= 2) || (c >= 4);
         @(negedge clk);
         g = {m1_gnt, m0_gnt};
         check_eq("t5_order", g, gq.pop_front());
         if (c == 3) check_eq("t5_owner_release", owner, 2'b10);
         if (c == 4) check_eq("t5_owner_switch", owner, 2'b01);
         tick();
         if (g[0]) m0_addr += 4;
      end
      m0_req = 0; m1_req = 0;
      repeat (3) tick();

      // 6: async reset in the middle of an M1 write with a read return on the port
      m1_req = 1; m1_we = 0; m1_addr = 32'h40;
      tick();
      tick();
      m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'hCAFEF00D;
      #1;
      check_eq("t6_pre_write", mem_write, 1);
      check_eq("t6_pre_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
      #1;
      reset = 1'b0;
      rq.delete();
      #1;
      check_eq("t6_write_drop", mem_write, 0);
      check_eq("t6_gnt_drop", {m1_gnt, m0_gnt}, 0);
      check_eq("t6_rvalid_drop", {m1_rvalid, m0_rvalid}, 0);
      check_eq("t6_owner", owner, 0);
      m0_req = 1; m0_we = 0; m0_addr = 32'h50;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_arb_idle", {m1_gnt, m0_gnt}, 0);
      tick();
      @(negedge clk);
      check_eq("t6_prefers_m0", {m1_gnt, m0_gnt}, 2'b01);
      tick();
      m0_req = 0;
      tick();
      @(negedge clk);
      check_eq("t6_m1_after", {m1_gnt, m0_gnt}, 2'b10);
      check_eq("t6_m1_waddr", mem_addr, 32'h44);
      tick();
      m1_req = 0;
      repeat (3) tick();
      check_eq("sb_drained", rq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
